reset_release_sequencer: RTL and testbench
==========================================

// Module: reset_release_sequencer
// PURPOSE
//  Orders reset release across N_DOM downstream reset domains.
//  Sits after the async-assert/sync-release reset synchronizer in the clk domain.
//  - Holds every domain in reset for a minimum time.
//  - Waits for PLL lock.
//  - Releases domains one at a time, index 0 first, with a programmable gap.
//  - Re-asserts all domains at once on loss of lock or a software reset request.
// PARAMETERS
//  N_DOM          4     number of reset domains (2..16)
//  CNT_W          8     width of inter-domain delay counter/config
//  HOLD_CYC       16    minimum cycles all domains stay asserted in ASSERT (>=1)
//  O_RESET_LEVEL  1'b0  asserted level of dom_rst_o bits (0 active-low, 1 active-high)
// PORTS
//  clk          in   1      system clock
//  rst_n        in   1      synchronous, active-low reset
//  pll_lock_i   in   1      PLL locked; synchronous to clk
//  sw_rst_i     in   1      software reset request, level; high = request
//  dly_cfg_i    in   CNT_W  inter-release gap minus 1, in cycles
//  dom_rst_o    out  N_DOM  per-domain reset; bit k = domain k; registered
//  seq_done_o   out  1      high when all domains are released; registered
//  state_o      out  2      FSM state (debug): 0 ASSERT, 1 WAIT_LOCK, 2 RELEASE, 3 DONE
// BEHAVIOUR
//  Reset (rst_n=0 at clk edge):
//   - state=ASSERT, hold_cnt=0, gap_cnt=0, idx=0.
//   - dom_rst_o = all bits O_RESET_LEVEL; seq_done_o=0.
//   - rst_n low mid-sequence gives the same values on the next edge.
//  ASSERT:
//   - All domains asserted.
//   - hold_cnt counts up; it is cleared every cycle sw_rst_i=1.
//   - Go to WAIT_LOCK when hold_cnt==HOLD_CYC-1 and sw_rst_i=0.
//  WAIT_LOCK:
//   - All domains asserted.
//   - When pll_lock_i=1 and sw_rst_i=0: latch dly_q<=dly_cfg_i, clear gap_cnt and idx, go to RELEASE.
//  RELEASE, each cycle:
//   - If gap_cnt==dly_q: dom_rst_o[idx] <= ~O_RESET_LEVEL, gap_cnt<=0, idx<=idx+1.
//     If idx==N_DOM-1, go to DONE and set seq_done_o<=1 on the same edge.
//   - Otherwise gap_cnt<=gap_cnt+1.
//   - Domain k deasserts (k+1)*(dly_q+1) edges after RELEASE entry.
//     With dly_q=0, one domain per cycle.
//   - Released bits stay released. dly_cfg_i changes have no effect until the next WAIT_LOCK exit.
//  DONE:
//   - All domains released; seq_done_o=1.
//  Abort, from WAIT_LOCK, RELEASE or DONE:
//   - Trigger: pll_lock_i=0 or sw_rst_i=1 (WAIT_LOCK reacts to sw_rst_i only).
//   - Next edge: all dom_rst_o asserted, seq_done_o=0, hold_cnt=0, state=ASSERT.
//   - Abort has priority over a release due on the same cycle.
//  Outputs are glitch-free: flop outputs only, no combinational path from inputs.
//  Counters never wrap: gap_cnt is bounded by dly_q, hold_cnt by HOLD_CYC-1.
// TESTING (N_DOM=4, HOLD_CYC=16, O_RESET_LEVEL=0)
//  1. Release rst_n, lock=1, dly_cfg=3.
//     -> dom_rst_o=4'b0000 for 16 cycles, WAIT_LOCK for 1 cycle.
//     -> Bits 0..3 go high at +4, +8, +12, +16 edges after RELEASE entry.
//     -> seq_done_o=1 at +16.
//  2. dly_cfg=0 -> dom_rst_o steps 0001, 0011, 0111, 1111 on consecutive edges.
//  3. lock=0 for 1 cycle after dom_rst_o=0011.
//     -> Next edge 0000, seq_done_o=0.
//     -> 16-cycle hold, then wait for lock, then full re-sequence.
//  4. sw_rst_i=1 for 40 cycles in DONE.
//     -> 0000 on the next edge, held 40+16 cycles before WAIT_LOCK.
//  5. rst_n=0 mid-RELEASE.
//     -> Next edge dom_rst_o=0000, state_o=0, seq_done_o=0.
//  6. dly_cfg changes 3->7 during RELEASE.
//     -> Gaps stay 4 cycles; the next sequence uses 8-cycle gaps.

Source files
------------

// File: rtl/reset_release_sequencer_if.sv
// Bus bundle for the reset release sequencer: lock/request/config inputs
// and the per-domain reset, done and debug state outputs.
interface reset_release_sequencer_if #(
    parameter int N_DOM = 4,
    parameter int CNT_W = 8
);
    logic             pll_lock_i;
    logic             sw_rst_i;
    logic [CNT_W-1:0] dly_cfg_i;
    logic [N_DOM-1:0] dom_rst_o;
    logic             seq_done_o;
    logic [1:0]       state_o;

    modport master (
        output pll_lock_i, sw_rst_i, dly_cfg_i,
        input  dom_rst_o, seq_done_o, state_o
    );

    modport slave (
        input  pll_lock_i, sw_rst_i, dly_cfg_i,
        output dom_rst_o, seq_done_o, state_o
    );
endinterface

// File: rtl/reset_release_sequencer.sv
// Reset release sequencer: holds all domains in reset, waits for PLL lock,
// then releases domains one at a time (index 0 first) with a programmable gap.
module reset_release_sequencer #(
    parameter int   N_DOM         = 4,
    parameter int   CNT_W         = 8,
    parameter int   HOLD_CYC      = 16,
    parameter logic O_RESET_LEVEL = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    reset_release_sequencer_if.slave   bus
);
    localparam int IDX_W  = (N_DOM > 1) ? $clog2(N_DOM) : 1;
    localparam int HOLD_W = (HOLD_CYC > 1) ? $clog2(HOLD_CYC) : 1;

    typedef enum logic [1:0] {
        ASSERT    = 2'd0,
        WAIT_LOCK = 2'd1,
        RELEASE   = 2'd2,
        DONE      = 2'd3
    } state_e;

    state_e             state_q, state_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic [CNT_W-1:0]   gap_q, gap_d;
    logic [CNT_W-1:0]   dly_q, dly_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [N_DOM-1:0]   dom_q, dom_d;
    logic               done_q, done_d;
    logic               abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ASSERT;
            hold_q  <= '0;
            gap_q   <= '0;
            dly_q   <= '0;
            idx_q   <= '0;
            dom_q   <= {N_DOM{O_RESET_LEVEL}};
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            gap_q   <= gap_d;
            dly_q   <= dly_d;
            idx_q   <= idx_d;
            dom_q   <= dom_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        gap_d   = gap_q;
        dly_d   = dly_q;
        idx_d   = idx_q;
        dom_d   = dom_q;
        done_d  = done_q;
        abort   = 1'b0;

        unique case (state_q)
            ASSERT: begin
                dom_d  = {N_DOM{O_RESET_LEVEL}};
                done_d = 1'b0;
                if (bus.sw_rst_i) begin
                    hold_d = '0;
                end else if (hold_q == HOLD_W'(HOLD_CYC - 1)) begin
                    state_d = WAIT_LOCK;
                    hold_d  = '0;
                end else begin
                    hold_d = hold_q + 1'b1;
                end
            end
            WAIT_LOCK: begin
                if (bus.sw_rst_i) begin
                    abort = 1'b1;
                end else if (bus.pll_lock_i) begin
                    dly_d   = bus.dly_cfg_i;
                    gap_d   = '0;
                    idx_d   = '0;
                    state_d = RELEASE;
                end
            end
            RELEASE: begin
                // Abort wins over a release falling due on the same cycle
                if (bus.sw_rst_i || !bus.pll_lock_i) begin
                    abort = 1'b1;
                end else if (gap_q == dly_q) begin
                    dom_d[idx_q] = ~O_RESET_LEVEL;
                    gap_d        = '0;
                    if (idx_q == IDX_W'(N_DOM - 1)) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.sw_rst_i || !bus.pll_lock_i) begin
                    abort = 1'b1;
                end
            end
            default: begin
                abort = 1'b1;
            end
        endcase

        if (abort) begin
            state_d = ASSERT;
            hold_d  = '0;
            dom_d   = {N_DOM{O_RESET_LEVEL}};
            done_d  = 1'b0;
        end
    end

    assign bus.dom_rst_o  = dom_q;
    assign bus.seq_done_o = done_q;
    assign bus.state_o    = state_q;
endmodule

// File: tb/tb_reset_release_sequencer.sv
// Bench for reset_release_sequencer: directed vector table, corner-case
// sequences and randomized stimulus against a timing-based reference model.
module tb_reset_release_sequencer;
    localparam int   N   = 4;
    localparam int   W   = 8;
    localparam int   H   = 16;
    localparam logic LVL = 1'b0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    reset_release_sequencer_if #(.N_DOM(N), .CNT_W(W)) bus();

    reset_release_sequencer #(
        .N_DOM(N), .CNT_W(W), .HOLD_CYC(H), .O_RESET_LEVEL(LVL)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Model: phase plus cycles elapsed in it; releases derived from time.
    int m_ph  = 0;
    int m_t   = 0;
    int m_dly = 0;

    typedef struct {
        logic       rn;
        logic       lk;
        logic       sw;
        logic [7:0] dly;
        int         n;
        logic [3:0] dom;
        logic       done;
        logic [1:0] st;
    } vec_t;
    vec_t tbl[$];

    task automatic add(logic rn, logic lk, logic sw, logic [7:0] dly, int n,
                       logic [3:0] dom, logic done, logic [1:0] st);
        vec_t v;
        v.rn = rn; v.lk = lk; v.sw = sw; v.dly = dly; v.n = n;
        v.dom = dom; v.done = done; v.st = st;
        tbl.push_back(v);
    endtask

    task automatic model_step();
        if (!rst_n) begin
            m_ph = 0;
            m_t  = 0;
        end else begin
            case (m_ph)
                0: begin
                    if (bus.sw_rst_i) m_t = 0;
                    else if (m_t == H - 1) begin m_ph = 1; m_t = 0; end
                    else m_t++;
                end
                1: begin
                    if (bus.sw_rst_i) begin m_ph = 0; m_t = 0; end
                    else if (bus.pll_lock_i) begin
                        m_ph = 2; m_t = 0; m_dly = int'(bus.dly_cfg_i);
                    end
                end
                default: begin
                    if (bus.sw_rst_i || !bus.pll_lock_i) begin
                        m_ph = 0; m_t = 0;
                    end else if (m_ph == 2) begin
                        m_t++;
                        if (m_t == N * (m_dly + 1)) m_ph = 3;
                    end
                end
            endcase
        end
    endtask

    function automatic logic [N+2:0] m_exp();
        int k;
        logic [N-1:0] m;
        k = (m_ph == 3) ? N : (m_ph == 2) ? m_t / (m_dly + 1) : 0;
        m = N'((1 << k) - 1);
        return {(LVL ? ~m : m), (m_ph == 3), 2'(m_ph)};
    endfunction

    function automatic logic [N+2:0] dut_out();
        return {bus.dom_rst_o, bus.seq_done_o, bus.state_o};
    endfunction

    function automatic logic [N+2:0] pk(logic [N-1:0] d, logic dn, logic [1:0] s);
        return {d, dn, s};
    endfunction

    task automatic chk(string nm, logic [N+2:0] got, logic [N+2:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got dom/done/st=%b want %b at %0t", nm, got, exp, $time);
        end
    endtask

    task automatic tick(int n);
        repeat (n) begin
            model_step();
            @(posedge clk);
            @(negedge clk);
            chk("model", dut_out(), m_exp());
        end
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.pll_lock_i = 1'b1;
        bus.sw_rst_i   = 1'b0;
        bus.dly_cfg_i  = 8'd3;

        // Power-up with dly 3, then sw reset and a dly 0 sequence
        add(0, 1, 0, 3,  2, 4'b0000, 0, 0);
        add(1, 1, 0, 3, 15, 4'b0000, 0, 0);
        add(1, 1, 0, 3,  1, 4'b0000, 0, 1);
        add(1, 1, 0, 3,  1, 4'b0000, 0, 2);
        add(1, 1, 0, 3,  3, 4'b0000, 0, 2);
        add(1, 1, 0, 3,  1, 4'b0001, 0, 2);
        add(1, 1, 0, 3,  4, 4'b0011, 0, 2);
        add(1, 1, 0, 3,  4, 4'b0111, 0, 2);
        add(1, 1, 0, 3,  3, 4'b0111, 0, 2);
        add(1, 1, 0, 3,  1, 4'b1111, 1, 3);
        add(1, 1, 1, 0,  1, 4'b0000, 0, 0);
        add(1, 1, 0, 0, 16, 4'b0000, 0, 1);
        add(1, 1, 0, 0,  1, 4'b0000, 0, 2);
        add(1, 1, 0, 0,  1, 4'b0001, 0, 2);
        add(1, 1, 0, 0,  1, 4'b0011, 0, 2);
        add(1, 1, 0, 0,  1, 4'b0111, 0, 2);
        add(1, 1, 0, 0,  1, 4'b1111, 1, 3);

        @(negedge clk);
        foreach (tbl[i]) begin
            rst_n          = tbl[i].rn;
            bus.pll_lock_i = tbl[i].lk;
            bus.sw_rst_i   = tbl[i].sw;
            bus.dly_cfg_i  = tbl[i].dly;
            tick(tbl[i].n);
            chk($sformatf("vec%0d", i), dut_out(),
                pk(tbl[i].dom, tbl[i].done, tbl[i].st));
        end

        // Lock loss after two domains released
        bus.sw_rst_i = 1'b1; tick(1);
        bus.sw_rst_i = 1'b0; tick(17);
        tick(2);
        chk("lock_pre", dut_out(), pk(4'b0011, 0, 2));
        bus.pll_lock_i = 1'b0; tick(1);
        chk("lock_drop", dut_out(), pk(4'b0000, 0, 0));
        bus.pll_lock_i = 1'b1; tick(15);
        chk("lock_hold", dut_out(), pk(4'b0000, 0, 0));
        tick(1);
        chk("lock_wait", dut_out(), pk(4'b0000, 0, 1));
        tick(1);
        chk("lock_rel", dut_out(), pk(4'b0000, 0, 2));
        tick(4);
        chk("lock_done", dut_out(), pk(4'b1111, 1, 3));

        // Long software reset in DONE
        bus.sw_rst_i = 1'b1; tick(1);
        chk("sw_first", dut_out(), pk(4'b0000, 0, 0));
        tick(39);
        chk("sw_held", dut_out(), pk(4'b0000, 0, 0));
        bus.sw_rst_i = 1'b0; tick(15);
        chk("sw_hold", dut_out(), pk(4'b0000, 0, 0));
        tick(1);
        chk("sw_wait", dut_out(), pk(4'b0000, 0, 1));

        // rst_n mid-RELEASE
        bus.dly_cfg_i = 8'd3; tick(1);
        tick(4);
        chk("rst_pre", dut_out(), pk(4'b0001, 0, 2));
        tick(2);
        rst_n = 1'b0; tick(1);
        chk("rst_mid", dut_out(), pk(4'b0000, 0, 0));
        rst_n = 1'b1;

        // Config change during RELEASE only applies to the next sequence
        tick(16);
        chk("dly_wait", dut_out(), pk(4'b0000, 0, 1));
        tick(1);
        bus.dly_cfg_i = 8'd7;
        tick(4);
        chk("dly_b0", dut_out(), pk(4'b0001, 0, 2));
        tick(4);
        chk("dly_b1", dut_out(), pk(4'b0011, 0, 2));
        tick(3);
        chk("dly_gap", dut_out(), pk(4'b0011, 0, 2));
        tick(1);
        chk("dly_b2", dut_out(), pk(4'b0111, 0, 2));
        tick(4);
        chk("dly_done", dut_out(), pk(4'b1111, 1, 3));
        bus.sw_rst_i = 1'b1; tick(1);
        bus.sw_rst_i = 1'b0; tick(16);
        tick(1);
        tick(7);
        chk("dly8_gap", dut_out(), pk(4'b0000, 0, 2));
        tick(1);
        chk("dly8_b0", dut_out(), pk(4'b0001, 0, 2));
        tick(8);
        chk("dly8_b1", dut_out(), pk(4'b0011, 0, 2));

        // Randomized run against the model
        for (int c = 0; c < 6000; c++) begin
            rst_n = ($urandom_range(0, 999) >= 3);
            if (bus.pll_lock_i) bus.pll_lock_i = ($urandom_range(0, 99) >= 2);
            else                bus.pll_lock_i = ($urandom_range(0, 99) < 30);
            bus.sw_rst_i = ($urandom_range(0, 99) < 2);
            if ($urandom_range(0, 9) == 0) begin
                if ($urandom_range(0, 19) == 0) bus.dly_cfg_i = 8'd20;
                else bus.dly_cfg_i = 8'($urandom_range(0, 4));
            end
            tick(1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
